// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bit-timer width; CLKS_PER_BIT-1 is the largest terminal count it must hold.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Word-side handshake of the UART receiver: data, valid/ready and per-word flags.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-runs after start, wraps at the programmed terminal count
// and emits a one-cycle tick on the terminal-count cycle.
module uart_bit_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          i_start,
  input  logic          i_clear,
  input  logic [CW-1:0] i_tc,
  output logic          o_tick
);

  logic          r_run;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
    end else if (r_run) begin
      r_cnt <= (r_cnt == i_tc) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = r_run && (r_cnt == i_tc);

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, optional parity, 1/2 stop
// bits, valid/ready word output with parity, framing and overrun flags.
//
//   state  | meaning
//   IDLE   | waiting for a synchronised high-to-low edge
//   START  | half bit wait, then confirm start bit (high = false start)
//   DATA   | one sample per bit period, shifted in LSB first
//   PARITY | single parity sample, compared with the data ones-count
//   STOP   | STOP_BITS samples, then one cycle to deliver the word
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            rx_in,
  output logic            busy,
  uart_rx_param_if.master m_if
);

  localparam int             CW        = cnt_width(CLKS_PER_BIT);
  localparam int             H         = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0]  TC_HALF   = CW'(H - 1);
  localparam logic [CW-1:0]  TC_FULL   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
  localparam bit             HAS_PAR   = (PARITY != PAR_NONE);

  logic                 r_sync1;
  logic                 r_sync2;
  logic [1:0]           r_prime;
  logic                 r_prev;
  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_acc;
  logic                 r_perr_acc;
  logic                 r_ferr_acc;
  logic                 r_fin;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_arm;
  logic                 w_tick;
  logic                 w_t_start;
  logic                 w_t_clear;
  logic [CW-1:0]        w_tc;
  logic                 w_accept;
  logic                 w_deliver;
  logic                 w_par_bad;

  // r_prime marks when r_sync2 holds a real line sample, so a line already low
  // out of reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prime <= 2'b00;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_prime <= {r_prime[0], 1'b1};
      r_prev  <= r_sync2 & r_prime[1];
    end
  end

  assign w_arm     = r_prev & ~r_sync2;
  assign w_tc      = (r_state == START) ? TC_HALF : TC_FULL;
  assign w_accept  = r_rx_valid && m_if.rx_ready;
  assign w_deliver = (r_state == STOP) && r_fin;
  assign w_par_bad = (PARITY == PAR_ODD) ? ~(r_par_acc ^ r_sync2) : (r_par_acc ^ r_sync2);

  uart_bit_timer #(
    .CW (CW)
  ) u_bit_timer (
    .clk     (clk),
    .rst_    (rst_),
    .i_start (w_t_start),
    .i_clear (w_t_clear),
    .i_tc    (w_tc),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_t_start   = 1'b0;
    w_t_clear   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arm) begin
          w_state_nxt = START;
          w_t_start   = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_sync2) begin
            w_state_nxt = IDLE;
            w_t_clear   = 1'b1;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_tick && (r_bit_cnt == LAST_DATA))
          w_state_nxt = HAS_PAR ? uart_pkg::PARITY : STOP;
      end
      uart_pkg::PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
      STOP: begin
        if (r_fin) w_state_nxt = IDLE;
        else if (w_tick && (r_bit_cnt == LAST_STOP)) w_t_clear = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_t_clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_acc    <= 1'b0;
      r_perr_acc   <= 1'b0;
      r_ferr_acc   <= 1'b0;
      r_fin        <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arm) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_fin      <= 1'b0;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
            r_par_acc <= r_par_acc ^ r_sync2;
            r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? 4'd0 : r_bit_cnt + 4'd1;
          end
        end
        uart_pkg::PARITY: begin
          if (w_tick) r_perr_acc <= w_par_bad;
        end
        STOP: begin
          if (r_fin) begin
            r_fin <= 1'b0;
          end else if (w_tick) begin
            if (!r_sync2) r_ferr_acc <= 1'b1;
            if (r_bit_cnt == LAST_STOP) r_fin     <= 1'b1;
            else                        r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        default: ;
      endcase

      // Delivery wins over accept; an accept in the same cycle only suppresses overrun.
      if (w_deliver) begin
        r_rx_data    <= r_shift;
        r_parity_err <= r_perr_acc;
        r_frame_err  <= r_ferr_acc;
        r_rx_valid   <= 1'b1;
        r_overrun    <= r_rx_valid & ~m_if.rx_ready;
      end else if (w_accept) begin
        r_rx_valid   <= 1'b0;
        r_parity_err <= 1'b0;
        r_frame_err  <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign busy            = (r_state != IDLE);
  assign m_if.rx_data    = r_rx_data;
  assign m_if.rx_valid   = r_rx_valid;
  assign m_if.parity_err = r_parity_err;
  assign m_if.frame_err  = r_frame_err;
  assign m_if.overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four configurations (8N1, 8E1, 8O1, 7N2) at 16 clocks per bit.
module tb_uart_rx_param;

  localparam int C      = 16;
  localparam int H      = C / 2;
  localparam int LAT_9  = 3 + H + 9 * C;
  localparam int LAT_10 = 3 + H + 10 * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_;
  logic rx_a, rx_e, rx_o, rx_s;
  logic busy_a, busy_e, busy_o, busy_s;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_e ();
  uart_rx_param_if #(.DATA_BITS(8)) if_o ();
  uart_rx_param_if #(.DATA_BITS(7)) if_s ();

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_(rst_), .rx_in(rx_a), .busy(busy_a), .m_if(if_a));
  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (
    .clk(clk), .rst_(rst_), .rx_in(rx_e), .busy(busy_e), .m_if(if_e));
  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o (
    .clk(clk), .rst_(rst_), .rx_in(rx_o), .busy(busy_o), .m_if(if_o));
  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_s (
    .clk(clk), .rst_(rst_), .rx_in(rx_s), .busy(busy_s), .m_if(if_s));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] w_v, w_b, w_pe, w_fe;
  logic [8:0] w_d [4];
  assign w_v  = {if_s.rx_valid, if_o.rx_valid, if_e.rx_valid, if_a.rx_valid};
  assign w_b  = {busy_s, busy_o, busy_e, busy_a};
  assign w_pe = {if_s.parity_err, if_o.parity_err, if_e.parity_err, if_a.parity_err};
  assign w_fe = {if_s.frame_err, if_o.frame_err, if_e.frame_err, if_a.frame_err};
  assign w_d[0] = 9'(if_a.rx_data);
  assign w_d[1] = 9'(if_e.rx_data);
  assign w_d[2] = 9'(if_o.rx_data);
  assign w_d[3] = 9'(if_s.rx_data);

  // Edge monitor: records the edge index of each rx_valid / busy transition.
  int         rise_cnt [4];
  int         rise_cyc [4];
  int         brise_cyc[4];
  int         bfall_cyc[4];
  int         busy_hi  [4];
  logic [8:0] cap_d    [4];
  logic       cap_pe   [4];
  logic       cap_fe   [4];
  logic [3:0] v_q = '0;
  logic [3:0] b_q = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_v[i] && !v_q[i]) begin
        rise_cnt[i] = rise_cnt[i] + 1;
        rise_cyc[i] = cyc;
        cap_d[i]    = w_d[i];
        cap_pe[i]   = w_pe[i];
        cap_fe[i]   = w_fe[i];
      end
      if (w_b[i] && !b_q[i]) brise_cyc[i] = cyc;
      if (!w_b[i] && b_q[i]) bfall_cyc[i] = cyc;
      if (w_b[i]) busy_hi[i] = busy_hi[i] + 1;
    end
    v_q = w_v;
    b_q = w_b;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic b);
    case (sel)
      0: rx_a = b;
      1: rx_e = b;
      2: rx_o = b;
      default: rx_s = b;
    endcase
  endtask

  // Called 1 time unit after an edge; e0 is the next edge, which samples the start bit.
  task automatic send(input int sel, input logic [15:0] bits, input int nbits, output int e0);
    e0 = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      set_rx(sel, bits[i]);
      tick(C);
    end
    set_rx(sel, 1'b1);
  endtask

  int e0, e1, e2, r0, h0;

  initial begin
    rst_ = 1'b0;
    rx_a = 1'b1; rx_e = 1'b1; rx_o = 1'b1; rx_s = 1'b1;
    if_a.rx_ready = 1'b1; if_e.rx_ready = 1'b1;
    if_o.rx_ready = 1'b1; if_s.rx_ready = 1'b1;
    tick(4);
    check("rst_valid", 32'(if_a.rx_valid), 0);
    check("rst_data",  32'(if_a.rx_data), 0);
    check("rst_flags", 32'({if_a.parity_err, if_a.frame_err, if_a.overrun}), 0);
    check("rst_busy",  32'(busy_a), 0);
    rst_ = 1'b1;
    tick(5);

    // 8N1 0xA5 with ready high: one-cycle valid pulse, exact latency
    send(0, 16'({1'b1, 8'hA5, 1'b0}), 10, e0);
    tick(20);
    check("a5_rise",      rise_cyc[0], e0 + LAT_9);
    check("a5_data",      32'(cap_d[0]), 32'hA5);
    check("a5_flags",     32'({cap_pe[0], cap_fe[0]}), 0);
    check("a5_busy_rise", brise_cyc[0], e0 + 2);
    check("a5_busy_fall", bfall_cyc[0], e0 + LAT_9);
    check("a5_pulse",     32'(if_a.rx_valid), 0);

    // 8E1 / 8O1, 0x37 has five ones
    send(1, 16'({1'b1, 1'b0, 8'h37, 1'b0}), 11, e0);
    tick(20);
    check("e_bad_rise", rise_cyc[1], e0 + LAT_10);
    check("e_bad_data", 32'(cap_d[1]), 32'h37);
    check("e_bad_perr", 32'(cap_pe[1]), 1);
    send(1, 16'({1'b1, 1'b1, 8'h37, 1'b0}), 11, e0);
    tick(20);
    check("e_ok_data", 32'(cap_d[1]), 32'h37);
    check("e_ok_perr", 32'(cap_pe[1]), 0);
    send(2, 16'({1'b1, 1'b1, 8'h37, 1'b0}), 11, e0);
    tick(20);
    check("o_bad_rise", rise_cyc[2], e0 + LAT_10);
    check("o_bad_perr", 32'(cap_pe[2]), 1);
    send(2, 16'({1'b1, 1'b0, 8'h37, 1'b0}), 11, e0);
    tick(20);
    check("o_ok_data", 32'(cap_d[2]), 32'h37);
    check("o_ok_perr", 32'({cap_pe[2], cap_fe[2]}), 0);

    // 7N2 with second stop bit low
    send(3, 16'({1'b0, 1'b1, 7'h2B, 1'b0}), 10, e0);
    tick(20);
    check("s_rise", rise_cyc[3], e0 + LAT_9);
    check("s_data", 32'(cap_d[3]), 32'h2B);
    check("s_ferr", 32'(cap_fe[3]), 1);
    check("s_perr", 32'(cap_pe[3]), 0);

    // 4-cycle glitch on idle 7N2 line
    r0 = rise_cnt[3];
    h0 = busy_hi[3];
    e0 = cyc + 1;
    rx_s = 1'b0;
    tick(4);
    rx_s = 1'b1;
    tick(40);
    check("gl_busy_len",  busy_hi[3] - h0, H);
    check("gl_busy_rise", brise_cyc[3], e0 + 2);
    check("gl_busy_fall", bfall_cyc[3], e0 + 2 + H);
    check("gl_no_valid",  rise_cnt[3] - r0, 0);

    // Overrun: 0x11 then 0x22 back-to-back, nothing accepted
    if_a.rx_ready = 1'b0;
    send(0, 16'({1'b1, 8'h11, 1'b0}), 10, e1);
    check("ov_hold_data", 32'(if_a.rx_data), 32'h11);
    check("ov_hold_ov",   32'({if_a.rx_valid, if_a.overrun}), 32'b10);
    send(0, 16'({1'b1, 8'h22, 1'b0}), 10, e2);
    tick(20);
    check("ov_first_rise", rise_cyc[0], e1 + LAT_9);
    check("ov_data",       32'(if_a.rx_data), 32'h22);
    check("ov_flags",      32'({if_a.rx_valid, if_a.overrun, if_a.parity_err, if_a.frame_err}), 32'b1100);
    if_a.rx_ready = 1'b1;
    tick(1);
    if_a.rx_ready = 1'b0;
    check("ov_clear", 32'({if_a.rx_valid, if_a.overrun, if_a.parity_err, if_a.frame_err}), 0);

    // Accept the held 0x11 on the exact cycle 0x22 is delivered
    send(0, 16'({1'b1, 8'h11, 1'b0}), 10, e1);
    send(0, 16'({8'h22, 1'b0}), 9, e2);
    tick(11);
    if_a.rx_ready = 1'b1;
    tick(1);
    if_a.rx_ready = 1'b0;
    check("sim_valid", 32'(if_a.rx_valid), 1);
    check("sim_data",  32'(if_a.rx_data), 32'h22);
    check("sim_ov",    32'(if_a.overrun), 0);
    tick(5);
    if_a.rx_ready = 1'b1;
    tick(2);

    // Break with nothing accepted, then a word that overruns it
    if_a.rx_ready = 1'b0;
    r0 = rise_cnt[0];
    send(0, 16'h0000, 12, e0);
    tick(20);
    check("brk_rise",  rise_cyc[0], e0 + LAT_9);
    check("brk_count", rise_cnt[0] - r0, 1);
    check("brk_data",  32'(if_a.rx_data), 0);
    check("brk_ferr",  32'(if_a.frame_err), 1);
    send(0, 16'({1'b1, 8'hC3, 1'b0}), 10, e0);
    tick(20);
    check("c3_data", 32'(if_a.rx_data), 32'hC3);
    check("c3_ov",   32'({if_a.overrun, if_a.frame_err}), 32'b10);

    // Reset in the middle of data bit 2 of 0x5A, line low across release
    if_a.rx_ready = 1'b1;
    rx_a = 1'b0; tick(C);
    rx_a = 1'b0; tick(C);
    rx_a = 1'b1; tick(C);
    rx_a = 1'b0; tick(H);
    check("mid_busy", 32'(busy_a), 1);
    rst_ = 1'b0;
    tick(2);
    rst_ = 1'b1;
    tick(1);
    check("mrst_outs", 32'({if_a.rx_valid, if_a.parity_err, if_a.frame_err, if_a.overrun, busy_a}), 0);
    check("mrst_data", 32'(if_a.rx_data), 0);
    r0 = rise_cnt[0];
    tick(3 * C);
    check("low_no_busy",  32'(busy_a), 0);
    check("low_no_frame", rise_cnt[0] - r0, 0);
    rx_a = 1'b1;
    tick(C);
    send(0, 16'({1'b1, 8'h5A, 1'b0}), 10, e0);
    tick(20);
    check("5a_rise",  rise_cyc[0], e0 + LAT_9);
    check("5a_data",  32'(cap_d[0]), 32'h5A);
    check("5a_flags", 32'({cap_pe[0], cap_fe[0]}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
